sisc_fetch_unit: RTL

//  Responder to the SISC control FSM's fetch/branch outputs (pc_rst, pc_write, pc_sel, br_sel, ir_load).

---
 rtl/sisc_fetch_unit.sv | 138 +++++++++++++
 1 files changed

// File: rtl/sisc_fetch_unit.sv
// SISC fetch unit: owns PC and IR and keeps one prefetched instruction word
// from instruction memory over a req/ack handshake.
//
// state  | meaning
// -------+------------------------------------------------------------------
// S_IDLE | no request outstanding; a request starts next cycle
// S_REQ  | imem_req high at the latched address, waiting for imem_ack
// S_FULL | prefetch buffer holds a valid word, waiting for ir_load
// S_DROP | request still outstanding but its data is stale; discard on ack
module sisc_fetch_unit #(
   parameter int PC_W = 16,
   parameter int IW   = 32
) (
   input  logic            clk,
   input  logic            rst_f,
   input  logic            pc_rst_i,
   input  logic            pc_write_i,
   input  logic            pc_sel_i,
   input  logic            br_sel_i,
   input  logic            ir_load_i,
   output logic            imem_req_o,
   output logic [PC_W-1:0] imem_addr_o,
   input  logic [IW-1:0]   imem_rdata_i,
   input  logic            imem_ack_i,
   output logic [IW-1:0]   ir_o,
   output logic [3:0]      opcode_o,
   output logic [3:0]      mm_o,
   output logic [PC_W-1:0] pc_o,
   output logic            fetch_stall_o
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_FULL = 2'd2,
      S_DROP = 2'd3
   } state_t;

   state_t          state_q, state_d;
   logic [PC_W-1:0] pc_q, pc_d;
   logic [PC_W-1:0] addr_q, addr_d;
   logic [IW-1:0]   ir_q, ir_d;
   logic [IW-1:0]   buf_q, buf_d;
   logic            buf_valid;
   logic            flush;
   logic [PC_W-1:0] offset;
   logic [PC_W-1:0] br_target;

   // Branch offset comes from the instruction currently held in IR.
   assign offset    = ir_q[PC_W-1:0];
   assign br_target = br_sel_i ? offset : pc_q + offset;
   // A PC clear or a taken branch invalidates anything prefetched or in flight.
   assign flush     = pc_rst_i | (pc_write_i & pc_sel_i);
   assign buf_valid = (state_q == S_FULL);

   // Next-state, PC, IR and prefetch buffer update.
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      addr_d  = addr_q;
      ir_d    = ir_q;
      buf_d   = buf_q;

      if (pc_rst_i) begin
         pc_d = '0;
      end else if (pc_write_i) begin
         pc_d = pc_sel_i ? br_target : pc_q + PC_W'(1);
      end

      unique case (state_q)
         S_IDLE: begin
            if (!pc_rst_i) begin
               state_d = S_REQ;
               addr_d  = pc_d;
            end
         end
         S_REQ: begin
            if (flush) begin
               // An ack coinciding with a flush returns stale data: restart
               // directly at the new PC, otherwise wait out the old request.
               if (imem_ack_i) begin
                  state_d = S_REQ;
                  addr_d  = pc_d;
               end else begin
                  state_d = S_DROP;
               end
            end else if (imem_ack_i) begin
               buf_d   = imem_rdata_i;
               state_d = S_FULL;
            end
         end
         S_FULL: begin
            if (flush) begin
               state_d = S_REQ;
               addr_d  = pc_d;
            end else if (ir_load_i) begin
               ir_d    = buf_q;
               state_d = S_REQ;
               addr_d  = pc_d;
            end
         end
         S_DROP: begin
            // Passing through IDLE gives the one-cycle gap in imem_req that
            // separates the discarded transfer from the fresh one.
            if (imem_ack_i) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State and datapath registers.
   always_ff @(posedge clk or negedge rst_f) begin
      if (!rst_f) begin
         state_q <= S_IDLE;
         pc_q    <= '0;
         addr_q  <= '0;
         ir_q    <= '0;
         buf_q   <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         addr_q  <= addr_d;
         ir_q    <= ir_d;
         buf_q   <= buf_d;
      end
   end

   assign imem_req_o    = (state_q == S_REQ) || (state_q == S_DROP);
   assign imem_addr_o   = addr_q;
   assign ir_o          = ir_q;
   assign opcode_o      = ir_q[IW-1:IW-4];
   assign mm_o          = ir_q[IW-5:IW-8];
   assign pc_o          = pc_q;
   assign fetch_stall_o = ir_load_i & ~buf_valid;

endmodule
